// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment encodings,
// blank/off patterns and the digit-to-anode helper.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_OFF    = 4'hF;

   // Active-low {g,f,e,d,c,b,a} patterns, indexed by nibble value
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [3:0] anode_for(input logic [1:0] sel);
      return ~(4'b0001 << sel);
   endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed hex display driver. The input value is snapshotted
// at the start of every frame so a frame never mixes old and new digits.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter bit BLANK_LZ    = 1'b0
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] value,
   input  logic [3:0]  dp_mask,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int              CNT_W    = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] r_refresh_cnt;
   logic [1:0]       r_digit_sel;
   logic [15:0]      r_value_q;
   logic [3:0]       r_dp_q;
   logic [3:0]       r_an;
   logic [6:0]       r_seg;
   logic             r_dp;

   logic             w_tick;
   logic             w_frame_start;
   logic [3:0]       w_nibbles [4];
   logic [3:0]       w_nibble;
   logic [6:0]       w_dec_seg;
   logic [3:0]       w_lz_zero;
   logic             w_blank;
   logic [3:0]       w_an_next;
   logic [6:0]       w_seg_next;
   logic             w_dp_next;

   assign w_tick        = (r_refresh_cnt == CNT_LAST);
   assign w_frame_start = (r_refresh_cnt == '0) && (r_digit_sel == 2'd0);

   // w_lz_zero[i]: nibbles i..3 all zero; digit 0 is never blanked
   assign w_lz_zero[0] = 1'b0;
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_nib
         assign w_nibbles[gi] = r_value_q[gi*4 +: 4];
      end
      for (gi = 1; gi < 4; gi++) begin : g_lz
         assign w_lz_zero[gi] = (r_value_q[15:gi*4] == '0);
      end
   endgenerate

   assign w_nibble = w_nibbles[r_digit_sel];
   assign w_blank  = BLANK_LZ && w_lz_zero[r_digit_sel];

   hex_to_seg7 u_dec (
      .i_nibble (w_nibble),
      .o_seg    (w_dec_seg)
   );

   always_comb begin
      w_an_next  = AN_OFF;
      w_seg_next = SEG_BLANK;
      w_dp_next  = 1'b1;
      if (en && !w_blank) begin
         w_an_next  = anode_for(r_digit_sel);
         w_seg_next = w_dec_seg;
         w_dp_next  = ~r_dp_q[r_digit_sel];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_refresh_cnt <= '0;
         r_digit_sel   <= 2'd0;
         r_value_q     <= 16'h0000;
         r_dp_q        <= 4'h0;
         r_an          <= AN_OFF;
         r_seg         <= SEG_BLANK;
         r_dp          <= 1'b1;
      end else begin
         r_refresh_cnt <= w_tick ? '0 : r_refresh_cnt + CNT_W'(1);
         if (w_tick) begin
            r_digit_sel <= r_digit_sel + 2'd1;
         end
         if (w_frame_start) begin
            r_value_q <= value;
            r_dp_q    <= dp_mask;
         end
         r_an  <= w_an_next;
         r_seg <= w_seg_next;
         r_dp  <= w_dp_next;
      end
   end

   assign an  = r_an;
   assign seg = r_seg;
   assign dp  = r_dp;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: three instances (RD=4, RD=4 with leading-zero
// blanking, RD=2) share stimulus; expected outputs are queued per edge.
module tb_seg7_scan;

   localparam logic [6:0] TBL [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
   localparam int RD [3] = '{4, 4, 2};
   localparam bit LZ [3] = '{1'b0, 1'b1, 1'b0};

   typedef struct {
      int         edge_no;
      int         k;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      bit         chk_seg;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic [15:0] value = 16'h0000;
   logic [3:0]  dp_mask = 4'h0;
   logic [3:0]  an_w  [3];
   logic [6:0]  seg_w [3];
   logic        dp_w  [3];

   int n_checks = 0;
   int n_errors = 0;
   int edge_cnt = 0;
   exp_t sb [$];

   int          m_cnt [3];
   int          m_sel [3];
   logic [15:0] m_vq  [3];
   logic [3:0]  m_dq  [3];

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   seg7_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_a (
      .clk(clk), .rst(rst), .en(en), .value(value), .dp_mask(dp_mask),
      .an(an_w[0]), .seg(seg_w[0]), .dp(dp_w[0]));
   seg7_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_b (
      .clk(clk), .rst(rst), .en(en), .value(value), .dp_mask(dp_mask),
      .an(an_w[1]), .seg(seg_w[1]), .dp(dp_w[1]));
   seg7_scan #(.REFRESH_DIV(2), .BLANK_LZ(1'b0)) dut_c (
      .clk(clk), .rst(rst), .en(en), .value(value), .dp_mask(dp_mask),
      .an(an_w[2]), .seg(seg_w[2]), .dp(dp_w[2]));

   // Advance the reference for one edge of instance k and queue its outputs
   task automatic model_edge(input int k);
      exp_t e;
      bit   blank;
      e.edge_no = edge_cnt + 1;
      e.k       = k;
      e.an      = 4'hF;
      e.seg     = 7'h7F;
      e.dp      = 1'b1;
      e.chk_seg = 1'b1;
      if (rst) begin
         m_cnt[k] = 0;
         m_sel[k] = 0;
         m_vq[k]  = 16'h0;
         m_dq[k]  = 4'h0;
      end else begin
         blank = LZ[k] && (m_sel[k] != 0) && ((m_vq[k] >> (4 * m_sel[k])) == 16'h0);
         if (blank) begin
            e.chk_seg = 1'b0;
         end else if (en) begin
            e.an  = ~(4'b0001 << m_sel[k]);
            e.seg = TBL[(m_vq[k] >> (4 * m_sel[k])) & 16'hF];
            e.dp  = ~m_dq[k][m_sel[k]];
         end
         if (m_cnt[k] == 0 && m_sel[k] == 0) begin
            m_vq[k] = value;
            m_dq[k] = dp_mask;
         end
         if (m_cnt[k] == RD[k] - 1) begin
            m_cnt[k] = 0;
            m_sel[k] = (m_sel[k] + 1) % 4;
         end else begin
            m_cnt[k] = m_cnt[k] + 1;
         end
      end
      sb.push_back(e);
   endtask

   task automatic step(input bit r, input bit e, input logic [15:0] v,
                       input logic [3:0] m, input int n);
      for (int i = 0; i < n; i++) begin
         rst = r; en = e; value = v; dp_mask = m;
         for (int k = 0; k < 3; k++) model_edge(k);
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic [3:0] a;
      logic [6:0] s;
      logic       d;
      while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
         e = sb.pop_front();
         a = an_w[e.k];
         s = seg_w[e.k];
         d = dp_w[e.k];
         n_checks++;
         if (a !== e.an) begin
            n_errors++;
            $display("FAIL an dut%0d edge %0d: got %b want %b", e.k, e.edge_no, a, e.an);
         end
         n_checks++;
         if ($countones(~a) > 1) begin
            n_errors++;
            $display("FAIL one_anode dut%0d edge %0d: got %b want at most one low", e.k, e.edge_no, a);
         end
         if (e.chk_seg) begin
            n_checks++;
            if (s !== e.seg || d !== e.dp) begin
               n_errors++;
               $display("FAIL seg_dp dut%0d edge %0d: got %h/%b want %h/%b",
                        e.k, e.edge_no, s, d, e.seg, e.dp);
            end
         end
         $display("edge %0d dut%0d an=%b seg=%h dp=%b", e.edge_no, e.k, a, s, d);
      end
   end

   initial begin
      #1;
      step(1'b1, 1'b1, 16'h12AF, 4'h0, 3);   // reset
      step(1'b0, 1'b1, 16'h12AF, 4'h0, 18);  // first frame + start of second
      step(1'b0, 1'b1, 16'h0003, 4'h0, 30);  // mid-frame change
      step(1'b0, 1'b1, 16'h0050, 4'h0, 32);  // leading-zero case
      step(1'b0, 1'b1, 16'h0000, 4'h0, 32);  // all-zero value
      step(1'b0, 1'b0, 16'h12AF, 4'h0, 16);  // display disabled for a frame
      step(1'b0, 1'b1, 16'h12AF, 4'h0, 26);  // resumed scan, up to digit 2
      step(1'b1, 1'b1, 16'hBEEF, 4'h0, 1);   // one-cycle reset pulse
      step(1'b0, 1'b1, 16'hBEEF, 4'h0, 20);  // fresh snapshot after restart
      step(1'b0, 1'b1, 16'h1234, 4'b0100, 32); // decimal point on digit 2
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
